// File: rtl/div_unit.sv
// Iterative restoring divider, one quotient bit per clock, fixed latency.
// Optional macro DIV_REMAINDER_EN adds iss_div_selrem to return the remainder.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iss_div_oper,
    input  logic             iss_div_unsig,
    input  logic [WIDTH-1:0] iss_div_rega,
    input  logic [WIDTH-1:0] iss_div_regb,
    input  logic [4:0]       iss_div_regdest,
    input  logic             iss_div_writereg,
`ifdef DIV_REMAINDER_EN
    input  logic             iss_div_selrem,
`endif
    output logic             div_iss_busy,
    output logic             div_wb_oper,
    output logic [4:0]       div_wb_regdest,
    output logic             div_wb_writereg,
    output logic [WIDTH-1:0] div_wb_wbvalue
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic             dz_q, dz_d;
    logic [4:0]       rd_q, rd_d;
    logic             wr_q, wr_d;
`ifdef DIV_REMAINDER_EN
    logic             sel_q, sel_d;
`endif

    logic             wb_oper_q, wb_oper_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             wb_wr_q, wb_wr_d;
    logic [WIDTH-1:0] wb_val_q, wb_val_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] q_fix;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] r_fix;
`endif

    // Operand magnitudes and one restoring subtract step on the live registers
    always_comb begin
        a_neg  = ~iss_div_unsig & iss_div_rega[WIDTH-1];
        b_neg  = ~iss_div_unsig & iss_div_regb[WIDTH-1];
        a_mag  = a_neg ? -iss_div_rega : iss_div_rega;
        b_mag  = b_neg ? -iss_div_regb : iss_div_regb;
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        q_fix  = dz_q ? '1 : (qsign_q ? -quo_q : quo_q);
`ifdef DIV_REMAINDER_EN
        r_fix  = rsign_q ? -rem_q : rem_q;
`endif
    end

    // Next-state logic: capture, iterate, then publish the sign-fixed result
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        dz_d      = dz_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
`ifdef DIV_REMAINDER_EN
        sel_d     = sel_q;
`endif
        wb_oper_d = 1'b0;
        wb_wr_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_val_d  = wb_val_q;
        unique case (state_q)
            IDLE: begin
                if (iss_div_oper) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    quo_d   = a_mag;
                    rem_d   = '0;
                    dvs_d   = b_mag;
                    qsign_d = a_neg ^ b_neg;
                    rsign_d = a_neg;
                    dz_d    = (iss_div_regb == '0);
                    rd_d    = iss_div_regdest;
                    wr_d    = iss_div_writereg;
`ifdef DIV_REMAINDER_EN
                    sel_d   = iss_div_selrem;
`endif
                end
            end
            CALC: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d   = IDLE;
                wb_oper_d = 1'b1;
                wb_wr_d   = wr_q;
                wb_rd_d   = rd_q;
`ifdef DIV_REMAINDER_EN
                wb_val_d  = sel_q ? r_fix : q_fix;
`else
                wb_val_d  = q_fix;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any op in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            dz_q      <= 1'b0;
            rd_q      <= '0;
            wr_q      <= 1'b0;
`ifdef DIV_REMAINDER_EN
            sel_q     <= 1'b0;
`endif
            wb_oper_q <= 1'b0;
            wb_rd_q   <= '0;
            wb_wr_q   <= 1'b0;
            wb_val_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            dz_q      <= dz_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
`ifdef DIV_REMAINDER_EN
            sel_q     <= sel_d;
`endif
            wb_oper_q <= wb_oper_d;
            wb_rd_q   <= wb_rd_d;
            wb_wr_q   <= wb_wr_d;
            wb_val_q  <= wb_val_d;
        end
    end

    assign div_iss_busy    = (state_q != IDLE);
    assign div_wb_oper     = wb_oper_q;
    assign div_wb_regdest  = wb_rd_q;
    assign div_wb_writereg = wb_wr_q;
    assign div_wb_wbvalue  = wb_val_q;

endmodule
